// File: rtl/comb_resp_checker.sv
// comb_resp_checker: scores a 4-input combinational DUT against an expected truth table over one 16-sample run.
// Optional response MISR enabled by defining COMB_RESP_MISR_EN; otherwise signature is tied to zero.
module comb_resp_checker #(
    parameter logic [15:0] EXP_TT = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [3:0]  abcd,
    input  logic        f,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  vec_count,
    output logic [4:0]  err_count,
    output logic [15:0] covered,
    output logic [3:0]  first_err_idx,
    output logic        first_err_vld,
    output logic [15:0] signature
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic accept, mismatch, last, start_run;
    assign accept    = (state == RUN) && in_valid;
    assign mismatch  = f != EXP_TT[abcd];
    assign last      = vec_count == 5'd15;
    assign start_run = (state != RUN) && start;
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        busy      = state == RUN;
        done      = state == DONE;
        pass      = done && (err_count == 5'd0) && (covered == 16'hFFFF);
        if (start_run)
            state_nxt = RUN;
        else if (accept && last)
            state_nxt = DONE;
    end
    always_ff @(posedge clk) begin
        if (reset || start_run) begin
            vec_count     <= '0;
            err_count     <= '0;
            covered       <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else if (accept) begin
            vec_count       <= vec_count + 5'd1;
            covered[abcd]   <= 1'b1;
            if (mismatch) begin
                err_count <= err_count + 5'd1;
                if (!first_err_vld) begin
                    first_err_idx <= abcd;
                    first_err_vld <= 1'b1;
                end
            end
        end
    end
`ifdef COMB_RESP_MISR_EN
    // Galois LFSR over f only, polynomial 0x1021, seeded all-ones
    logic [15:0] sig_q;
    always_ff @(posedge clk) begin
        if (reset || start_run)
            sig_q <= 16'hFFFF;
        else if (accept)
            sig_q <= {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ f) ? 16'h1021 : 16'h0000);
    end
    assign signature = sig_q;
`else
    assign signature = 16'h0000;
`endif
endmodule

// File: tb/tb_comb_resp_checker.sv
// tb_comb_resp_checker: directed self-checking bench for comb_resp_checker with EXP_TT = 16'hF888 (f = AB | CD).
module tb_comb_resp_checker;
    localparam logic [15:0] EXP = 16'hF888;
`ifdef COMB_RESP_MISR_EN
    localparam bit MISR = 1'b1;
`else
    localparam bit MISR = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0, f = 1'b0;
    logic [3:0] abcd = '0;
    logic busy, done, pass, first_err_vld;
    logic [4:0] vec_count, err_count;
    logic [15:0] covered, signature;
    logic [3:0] first_err_idx;
    logic [15:0] tt = EXP;
    logic [15:0] msig = 16'hFFFF;
    int n_checks = 0, n_fail = 0;

    comb_resp_checker #(.EXP_TT(EXP)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .abcd(abcd), .f(f),
        .busy(busy), .done(done), .pass(pass), .vec_count(vec_count), .err_count(err_count),
        .covered(covered), .first_err_idx(first_err_idx), .first_err_vld(first_err_vld),
        .signature(signature)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_sig();
        return MISR ? msig : 16'h0000;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        msig  = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
    endtask

    // one valid sample; inv flips the expected response to force a mismatch
    task automatic sample(input logic [3:0] c, input bit inv);
        logic fv;
        fv = tt[c] ^ inv;
        in_valid = 1'b1;
        abcd = c;
        f = fv;
        if (busy)
            msig = {msig[14:0], 1'b0} ^ ((msig[15] ^ fv) ? 16'h1021 : 16'h0000);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " pass"}, pass, 0);
        check({tag, " vec"}, vec_count, 0);
        check({tag, " err"}, err_count, 0);
        check({tag, " cov"}, covered, 0);
        check({tag, " idx"}, first_err_idx, 0);
        check({tag, " vld"}, first_err_vld, 0);
        check({tag, " sig"}, signature, MISR ? 16'hFFFF : 16'h0000);
    endtask

    task automatic check_good_run(input string tag);
        check({tag, " done"}, done, 1);
        check({tag, " busy"}, busy, 0);
        check({tag, " pass"}, pass, 1);
        check({tag, " err"}, err_count, 0);
        check({tag, " vec"}, vec_count, 16);
        check({tag, " cov"}, covered, 16'hFFFF);
        check({tag, " vld"}, first_err_vld, 0);
        check({tag, " sig"}, signature, exp_sig());
    endtask

    initial begin
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        check_all_zero("reset");
        sample(4'd3, 0);
        check("idle ignores valid", vec_count, 0);

        // full ascending sweep with correct responses
        pulse_start();
        check("start busy", busy, 1);
        for (int i = 0; i < 15; i++) sample(4'(i), 0);
        check("15 samples not done", done, 0);
        check("15 samples vec", vec_count, 15);
        sample(4'd15, 0);
        check_good_run("sweep");
        sample(4'd2, 1);
        check("done ignores valid vec", vec_count, 16);
        check("done ignores valid err", err_count, 0);

        // restart from DONE, mismatches at codes 5 and 10
        pulse_start();
        check("restart vec", vec_count, 0);
        check("restart cov", covered, 0);
        check("restart busy", busy, 1);
        for (int i = 0; i < 16; i++) sample(4'(i), (i == 5) || (i == 10));
        check("err run done", done, 1);
        check("err run err", err_count, 2);
        check("err run idx", first_err_idx, 5);
        check("err run vld", first_err_vld, 1);
        check("err run pass", pass, 0);
        check("err run sig", signature, exp_sig());

        // restart from DONE again with a clean sweep
        pulse_start();
        check("rerun err cleared", err_count, 0);
        check("rerun vld cleared", first_err_vld, 0);
        check("rerun sig seed", signature, MISR ? 16'hFFFF : 16'h0000);
        for (int i = 0; i < 16; i++) sample(4'(i), 0);
        check_good_run("rerun");

        // duplicate code 0 only
        pulse_start();
        for (int i = 0; i < 16; i++) sample(4'd0, 0);
        check("dup done", done, 1);
        check("dup cov", covered, 16'h0001);
        check("dup err", err_count, 0);
        check("dup vec", vec_count, 16);
        check("dup pass", pass, 0);

        // alternate-cycle valid with a start pulse mid-run
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            sample(4'(i), 0);
            if (i == 15) break;
            if (i == 8) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (i == 14) check("alt 15 not done", done, 0);
        end
        check_good_run("alt");

        // reset mid-run, then samples without start
        pulse_start();
        for (int i = 0; i < 7; i++) sample(4'(i), 0);
        check("pre-reset vec", vec_count, 7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 7; i < 16; i++) sample(4'(i), 0);
        check_all_zero("abandon");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
